// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory port, redirect request and decode handshake.
interface fetch_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] instruction_address;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [DATA_WIDTH-1:0] out_instruction;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic                  out_valid;
   logic                  out_ready;

   // Sequencer side
   modport master (
      output instruction_address,
      input  instruction,
      input  redirect_valid,
      input  redirect_pc,
      output out_instruction,
      output out_pc,
      output out_valid,
      input  out_ready
   );

   // Memory / execute / decode side
   modport slave (
      input  instruction_address,
      output instruction,
      output redirect_valid,
      output redirect_pc,
      input  out_instruction,
      input  out_pc,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter controller: walks instruction memory, issues words to decode
// over valid/ready, and handles stall, redirect, start and halt.
module fetch_sequencer #(
   parameter int unsigned           ADDR_WIDTH = 5,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           RESET_PC   = 0,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(32'hFFFF_FFFF),
   parameter int unsigned           CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   fetch_sequencer_if.master    bus,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] issue_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  transfer;

   // Memory address is the PC register itself, so it is stable during stalls.
   assign bus.instruction_address = pc;

   // Decode sampled the word this cycle; counted even if a redirect flushes it.
   assign transfer = bus.out_valid && bus.out_ready;

   // PC, state, output word and issue counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= ST_IDLE;
         pc                  <= ADDR_WIDTH'(RESET_PC);
         bus.out_valid       <= 1'b0;
         bus.out_instruction <= '0;
         bus.out_pc          <= '0;
         halted              <= 1'b0;
         issue_count         <= '0;
      end else begin
         if (transfer && (issue_count != {CNT_WIDTH{1'b1}})) begin
            issue_count <= issue_count + CNT_WIDTH'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               if (bus.redirect_valid) begin
                  pc            <= bus.redirect_pc;
                  bus.out_valid <= 1'b0;
               end else if (!bus.out_valid || bus.out_ready) begin
                  if (bus.instruction == HALT_WORD) begin
                     // PC stays on the halt word; it is never issued.
                     state         <= ST_HALT;
                     halted        <= 1'b1;
                     bus.out_valid <= 1'b0;
                  end else begin
                     bus.out_instruction <= bus.instruction;
                     bus.out_pc          <= pc;
                     bus.out_valid       <= 1'b1;
                     pc                  <= pc + ADDR_WIDTH'(1);
                  end
               end
            end

            ST_HALT: begin
               if (start) begin
                  pc     <= ADDR_WIDTH'(RESET_PC);
                  state  <= ST_FETCH;
                  halted <= 1'b0;
               end
            end

            default: begin
               state         <= ST_IDLE;
               halted        <= 1'b0;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stream, stall, redirect, halt/restart,
// mid-stream reset and PC wrap against hand-computed expectations.
module tb_fetch_sequencer;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic          halted;
   logic [CW-1:0] issue_count;
   logic [DW-1:0] mem [32];

   int n_checks;
   int n_errors;

   fetch_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fetch_sequencer #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RESET_PC  (0),
      .HALT_WORD (32'hFFFF_FFFF),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .halted     (halted),
      .issue_count(issue_count)
   );

   // Combinational instruction memory
   assign bus.instruction = mem[bus.instruction_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_word(input string tag, input int pc_exp);
      check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " pc"}, 32'(bus.out_pc), 32'(pc_exp));
      check({tag, " instr"}, bus.out_instruction, mem[pc_exp]);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000;
      mem[0] = 32'h2001_0005;  // addi $1,$0,5
      mem[1] = 32'h2002_0003;  // addi $2,$0,3
      mem[2] = 32'h0022_1820;  // add  $3,$1,$2
      mem[3] = 32'hAC03_0000;  // sw   $3,0($0)
      mem[4] = 32'h8C04_0000;  // lw   $4,0($0)
      mem[5] = 32'h1064_0001;  // beq  $3,$4,+1
      mem[6] = 32'hFFFF_FFFF;  // halt

      reset              = 1'b1;
      start              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b1;
      tick();
      tick();

      // Reset state
      check("rst valid", 32'(bus.out_valid), 32'd0);
      check("rst halted", 32'(halted), 32'd0);
      check("rst count", 32'(issue_count), 32'd0);
      check("rst addr", 32'(bus.instruction_address), 32'd0);
      check("rst out_pc", 32'(bus.out_pc), 32'd0);
      check("rst out_instr", bus.out_instruction, 32'd0);

      // IDLE ignores redirect and does not load
      reset              = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 5'd7;
      tick();
      bus.redirect_valid = 1'b0;
      check("idle redirect addr", 32'(bus.instruction_address), 32'd0);
      check("idle valid", 32'(bus.out_valid), 32'd0);

      // Stream 0..5 then halt
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start valid", 32'(bus.out_valid), 32'd0);
      check("start addr", 32'(bus.instruction_address), 32'd0);
      tick();
      for (int k = 0; k < 6; k++) begin
         check_word($sformatf("stream%0d", k), k);
         check($sformatf("stream%0d count", k), 32'(issue_count), 32'(k));
         tick();
      end
      check("halt halted", 32'(halted), 32'd1);
      check("halt count", 32'(issue_count), 32'd6);
      check("halt valid", 32'(bus.out_valid), 32'd0);
      check("halt addr", 32'(bus.instruction_address), 32'd6);

      // HALT ignores redirect
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 5'd9;
      tick();
      bus.redirect_valid = 1'b0;
      check("halt redirect addr", 32'(bus.instruction_address), 32'd6);
      check("halt redirect halted", 32'(halted), 32'd1);

      // Restart from RESET_PC
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart halted", 32'(halted), 32'd0);
      check("restart addr", 32'(bus.instruction_address), 32'd0);
      check("restart valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_word("restart first", 0);
      tick();
      check_word("restart second", 1);
      tick();
      check_word("pre-stall", 2);
      check("pre-stall count", 32'(issue_count), 32'd8);

      // Stall three cycles on out_pc=2
      bus.out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         check_word($sformatf("stall%0d", s), 2);
         check($sformatf("stall%0d addr", s), 32'(bus.instruction_address), 32'd3);
         check($sformatf("stall%0d count", s), 32'(issue_count), 32'd8);
      end
      bus.out_ready = 1'b1;
      tick();
      check_word("release", 3);
      check("release count", 32'(issue_count), 32'd9);
      tick();
      check_word("pre-redirect", 4);

      // Redirect to 1 while word 4 is being transferred
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 5'd1;
      tick();
      bus.redirect_valid = 1'b0;
      check("redirect flush valid", 32'(bus.out_valid), 32'd0);
      check("redirect addr", 32'(bus.instruction_address), 32'd1);
      check("redirect count", 32'(issue_count), 32'd11);
      for (int k = 1; k < 4; k++) begin
         tick();
         check_word($sformatf("redir%0d", k), k);
      end
      check("redir count", 32'(issue_count), 32'd13);

      // Reset mid-stream with count 5
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) tick();
      check_word("midrst pre", 5);
      check("midrst pre count", 32'(issue_count), 32'd5);
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("midrst valid", 32'(bus.out_valid), 32'd0);
      check("midrst count", 32'(issue_count), 32'd0);
      check("midrst addr", 32'(bus.instruction_address), 32'd0);
      tick();
      check("midrst idle valid", 32'(bus.out_valid), 32'd0);
      check("midrst idle addr", 32'(bus.instruction_address), 32'd0);

      // Wrap: no halt word, redirect to 30
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | 32'(i);
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 5'd30;
      tick();
      bus.redirect_valid = 1'b0;
      check("wrap redirect addr", 32'(bus.instruction_address), 32'd30);
      tick();
      check_word("wrap30", 30);
      tick();
      check_word("wrap31", 31);
      check("wrap addr", 32'(bus.instruction_address), 32'd0);
      tick();
      check_word("wrap0", 0);
      tick();
      check_word("wrap1", 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller that sequences the 32-entry instruction memory: drives its word address, captures the combinational read word, and presents it to the decode stage over a valid/ready handshake.
- Handles stall (back-pressure), redirect (branch/jump/jal/jr target from execute), start and halt.
- Sits between the instruction memory and the IF/ID boundary of the MIPS core.

Parameters:
- ADDR_WIDTH, 5, word-address width; the PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value after reset and after restart from HALT.
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetching; it is never issued downstream.
- CNT_WIDTH, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins fetching from the PC (IDLE), or restarts at RESET_PC (HALT).
- instruction_address  output  ADDR_WIDTH  word address to the instruction memory; always equals the PC register.
- instruction  input  DATA_WIDTH  combinational read data for instruction_address, same cycle.
- redirect_valid  input  1  control-flow change request.
- redirect_pc  input  ADDR_WIDTH  target word address.
- out_instruction  output  DATA_WIDTH  issued instruction.
- out_pc  output  ADDR_WIDTH  address of out_instruction.
- out_valid  output  1  out_instruction/out_pc are valid.
- out_ready  input  1  decode accepts; a transfer occurs when out_valid && out_ready.
- halted  output  1  high while in HALT.
- issue_count  output  CNT_WIDTH  number of completed transfers, saturating.

Behaviour:
- Reset (synchronous, active-high; has priority over all inputs):
  - pc=RESET_PC, state=IDLE, out_valid=0, out_instruction=0, out_pc=0, halted=0, issue_count=0.
  - Reset asserted mid-operation discards the pending output word.
- States: IDLE, FETCH, HALT. halted=1 exactly when state=HALT (registered).
- IDLE:
  - start moves the state to FETCH next cycle; pc is unchanged.
  - redirect_valid is ignored.
  - No loads occur.
- FETCH, evaluated each cycle in this priority order:
  1. Redirect. If redirect_valid: pc<=redirect_pc, out_valid<=0 (flush, including any un-transferred word), no load. The redirect wins even when out_ready=1 and out_valid=1 that cycle; the word is still counted as transferred, because decode sampled it.
  2. Load. If no redirect and (!out_valid || out_ready):
     - If instruction==HALT_WORD: state<=HALT, pc holds (points at the halt word), out_valid<=0.
     - Else: out_instruction<=instruction, out_pc<=pc, out_valid<=1, pc<=pc+1 (from 2^ADDR_WIDTH-1 it wraps to 0).
  3. Hold. If out_valid && !out_ready: all registers hold; instruction_address is stable.
- Throughput and latency:
  - Throughput is one instruction per cycle while out_ready=1.
  - Latency from pc to out_valid is 1 cycle.
  - After a redirect, the first target word is valid 2 cycles after the cycle redirect_valid was sampled: 1 cycle to load the PC, 1 cycle to fetch.
- HALT:
  - No loads; redirect_valid is ignored.
  - start: pc<=RESET_PC, state<=FETCH.
- start while in FETCH is ignored.
- issue_count increments on each transfer cycle (out_valid && out_ready) in any state and saturates at all-ones.
- Simultaneous transfer and load in the same cycle is the normal streaming case: issue_count increments once, and out_valid stays 1.

Test Plan:
- Stream: memory holds addi,addi,add,sw,lw,beq at 0..5 and HALT_WORD at 6; reset, start, out_ready=1 -> out_pc 0..5 on consecutive cycles, then halted=1, issue_count=6, out_valid=0, instruction_address=6.
- Stall: out_ready=0 for 3 cycles while out_pc=2 is valid -> out_instruction, out_pc and instruction_address (3) held; on release the next word issued has out_pc=3 and no instruction is lost or duplicated.
- Redirect: at out_pc=4, pulse redirect_valid with redirect_pc=1 -> out_valid=0 for the next cycle, then out_pc=1,2,...; address 5 is never issued.
- Wrap: no HALT_WORD in memory, run with out_ready=1 -> out_pc sequence 30, 31, 0, 1.
- Halt/restart: in HALT, pulse redirect_valid with redirect_pc=9 -> ignored and pc unchanged; pulse start -> state FETCH, first out_pc=RESET_PC=0.
- Reset mid-stream: assert reset while out_valid=1 and issue_count=5 -> next cycle out_valid=0, issue_count=0, state IDLE, instruction_address=0; a start pulse concurrent with reset is ignored.
